// File: rtl/config_frame_pkg.sv
// Shared types and default geometry for the configuration frame controller.
// No logic here. Timing and backpressure are defined by the modules that import it.
package config_frame_pkg;

    localparam int DEF_FRAME_BITS    = 32;
    localparam int DEF_NUM_FRAMES    = 20;
    localparam int DEF_ADDR_W        = 5;
    localparam int DEF_STROBE_CYCLES = 2;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

endpackage

// File: rtl/config_frame_strobe_dec.sv
// Decodes a frame address and an enable into a one-hot latch-enable vector.
// Combinational, with zero latency. There is no backpressure, and an out-of-range address decodes to all-zero.
module config_frame_strobe_dec #(
    parameter int NUM_FRAMES = 20,
    parameter int ADDR_W     = 5
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  en,
    output logic [NUM_FRAMES-1:0] strobe
);

    always_comb begin
        strobe = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            strobe[i] = en && (32'(addr) == i);
        end
    end

endmodule

// File: rtl/config_frame_ctrl.sv
// Writes one configuration frame per request: IDLE -> SETUP -> STROBE x STROBE_CYCLES -> HOLD.
// The strobe starts two cycles after accept. s_ready is high only in IDLE; CFG_PARITY_EN adds an s_parity check.
module config_frame_ctrl
    import config_frame_pkg::*;
#(
    parameter int FRAME_BITS    = DEF_FRAME_BITS,
    parameter int NUM_FRAMES    = DEF_NUM_FRAMES,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_W-1:0]     s_addr,
    input  logic [FRAME_BITS-1:0] s_data,
`ifdef CFG_PARITY_EN
    input  logic                  s_parity,
`endif
    output logic [FRAME_BITS-1:0] FrameData,
    output logic [NUM_FRAMES-1:0] FrameStrobe,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  err
);

    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [FRAME_BITS-1:0]   data_q;
    logic                    good_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_FRAMES-1:0]   strobe_q, strobe_d;
    logic [15:0]             count_q;
    logic                    err_q;
    logic                    accept;
    logic                    frame_ok;
    logic                    strobe_en;

    assign s_ready     = (state_q == IDLE) && !reset;
    assign accept      = s_valid && s_ready;
    assign busy        = (state_q != IDLE);
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign frame_count = count_q;
    assign err         = err_q;

    always_comb begin
        frame_ok = (32'(s_addr) < NUM_FRAMES);
`ifdef CFG_PARITY_EN
        if ((^s_data) != s_parity) begin
            frame_ok = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        strobe_en = 1'b0;
        case (state_q)
            IDLE:   if (accept) state_d = SETUP;
            SETUP:  state_d = STROBE;
            STROBE: if (cnt_q == CNT_LAST) state_d = HOLD;
            HOLD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The strobe is computed one cycle ahead so the output comes straight from a flop.
        strobe_en = (state_d == STROBE) && good_q;
    end

    config_frame_strobe_dec #(
        .NUM_FRAMES(NUM_FRAMES),
        .ADDR_W    (ADDR_W)
    ) u_dec (
        .addr  (addr_q),
        .en    (strobe_en),
        .strobe(strobe_d)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            good_q   <= 1'b0;
            cnt_q    <= '0;
            strobe_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            if (accept) begin
                addr_q <= s_addr;
                data_q <= s_data;
                good_q <= frame_ok;
                if (!frame_ok) err_q <= 1'b1;
            end
            if (state_q == STROBE) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if ((state_q == HOLD) && good_q && (count_q != COUNT_MAX)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule

// File: doc/config_frame_ctrl.md
CONFIG_FRAME_CTRL -- requirements
Module: config_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 32: width of one configuration frame (bits per latch row).
REQ-002 SHALL have parameter NUM_FRAMES, default 20: number of frame-strobe lines (latch columns).
REQ-003 SHALL have parameter ADDR_W, default 5: frame-address width, with 2**ADDR_W >= NUM_FRAMES.
REQ-004 SHALL have parameter STROBE_CYCLES, default 2, legal range >= 1: latch-enable pulse length in cycles.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port s_valid, input, 1 bit: frame write request.
REQ-008 SHALL have port s_ready, output, 1 bit: controller can accept a frame.
REQ-009 SHALL have port s_addr, input, ADDR_W bits: target frame index.
REQ-010 SHALL have port s_data, input, FRAME_BITS bits: frame payload.
REQ-011 SHALL have port s_parity, input, 1 bit: even parity of s_data; present only when CFG_PARITY_EN is defined.
REQ-012 SHALL have port FrameData, output, FRAME_BITS bits: data driven to the latch D inputs.
REQ-013 SHALL have port FrameStrobe, output, NUM_FRAMES bits: latch E inputs; one-hot or all-zero.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port frame_count, output, 16 bits: number of frames written.
REQ-016 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-017 FSM SHALL have states IDLE, SETUP, STROBE, HOLD; s_ready SHALL be 1 only in IDLE.
REQ-018 On the edge where s_valid && s_ready: register s_data into FrameData and s_addr internally; go to SETUP.
REQ-019 SETUP SHALL last 1 cycle with FrameStrobe all-zero and FrameData stable; then go to STROBE.
REQ-020 STROBE SHALL last exactly STROBE_CYCLES cycles with FrameStrobe[addr]=1 and all other bits 0; then go to HOLD.
REQ-021 HOLD SHALL last 1 cycle with FrameStrobe all-zero and FrameData unchanged; then go to IDLE and increment frame_count, saturating at 0xFFFF.
REQ-022 Timing: accept at edge n -> SETUP during cycle n+1, strobe during cycles n+2..n+1+STROBE_CYCLES, s_ready high again in cycle n+3+STROBE_CYCLES; peak throughput one frame per 3+STROBE_CYCLES cycles.
REQ-023 FrameData SHALL change only on an accept edge; it SHALL hold its value in IDLE.
REQ-024 FrameStrobe SHALL be registered (glitch-free) and never have more than one bit set.
REQ-025 An accepted frame with s_addr >= NUM_FRAMES SHALL run the full FSM sequence with FrameStrobe all-zero, SHALL set err, and SHALL NOT increment frame_count.
REQ-026 s_valid while busy SHALL be ignored; the request is held off by s_ready=0.

Reset
REQ-027 Asserting reset SHALL immediately (asynchronously) force state to IDLE, FrameStrobe=0, FrameData=0, frame_count=0, err=0, busy=0, s_ready=0 while reset is high.
REQ-028 Reset mid-STROBE SHALL drop the strobe at once; the interrupted frame SHALL NOT be counted.
REQ-029 After deassertion, s_ready SHALL be 1 from the first cycle.

Configuration
REQ-030 Macro CFG_PARITY_EN defined: on accept, if ^s_data != s_parity, set err, and the frame SHALL run the FSM with no strobe and SHALL NOT be counted.
REQ-031 Macro CFG_PARITY_EN undefined: the s_parity port and the parity logic SHALL be absent.

Structure
REQ-032 Package config_frame_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 Sub-module config_frame_strobe_dec SHALL decode addr plus enable into the one-hot FrameStrobe, outputting zero when out of range.

Verification
REQ-034 Reset, then write addr=3, data=0xA5A5_0F0F -> FrameData=0xA5A5_0F0F from cycle n+1, FrameStrobe=0x00008 for 2 cycles, frame_count=1, s_ready back in cycle n+5.
REQ-035 Back-to-back s_valid held high for addrs 0,19 -> two non-overlapping strobes (bits 0 and 19), each preceded by a 1-cycle setup gap and followed by a 1-cycle hold gap.
REQ-036 Write addr=25 -> no strobe, err=1, frame_count unchanged, FSM returns to IDLE after 5 cycles.
REQ-037 Assert reset during the second STROBE cycle -> FrameStrobe=0 that same cycle, frame_count=0, err=0.
REQ-038 CFG_PARITY_EN defined, data=0x1 with s_parity=0 -> err=1, no strobe; with s_parity=1 -> normal write.
REQ-039 Perform 65536 writes -> frame_count saturates at 0xFFFF.
